hal_mux4_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 datapath mux (HAL_MUX4 select encoding) between four requesters. It drives the mux selects S1/S2, issues one-hot grants and registers the selected word onto a valid/ready output port. A mandatory one-cycle cooldown between owners keeps select changes away from live data. It sits in front of any shared single-output resource, such as a bus, a global-buffer feed or a port into a downstream block.

---
 rtl/hal_mux4_rr_arbiter_if.sv | 43 ++++
 rtl/hal_mux4_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hal_mux4_rr_arbiter_if.sv
// Bundle of requester, mux-select and output-port signals for hal_mux4_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and consumes the output port.
// Optional macro HAL_ARB_LOCK_EN adds the LOCK signal.
interface hal_mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       REQ;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             READY;
  logic [3:0]       GNT;
  logic             S1;
  logic             S2;
  logic [WIDTH-1:0] O;
  logic             O_VALID;
  logic             BUSY;
`ifdef HAL_ARB_LOCK_EN
  logic             LOCK;

  modport master (
    output REQ, A, B, C, D, READY, LOCK,
    input  GNT, S1, S2, O, O_VALID, BUSY
  );

  modport slave (
    input  REQ, A, B, C, D, READY, LOCK,
    output GNT, S1, S2, O, O_VALID, BUSY
  );
`else
  modport master (
    output REQ, A, B, C, D, READY,
    input  GNT, S1, S2, O, O_VALID, BUSY
  );

  modport slave (
    input  REQ, A, B, C, D, READY,
    output GNT, S1, S2, O, O_VALID, BUSY
  );
`endif
endinterface

// File: rtl/hal_mux4_rr_arbiter.sv
// Round-robin arbiter sharing one HAL_MUX4-encoded 4:1 mux between four
// requesters, with a registered valid/ready output port and a one-cycle
// cooldown between owners so the selects never move under live data.
// Optional macro HAL_ARB_LOCK_EN: LOCK input suppresses the HOLD_MAX release.
module hal_mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input logic                  CLK,
  input logic                  RST,
  hal_mux4_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_MAX);

  state_t           state, state_nx;
  logic [1:0]       owner, owner_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [3:0]       gnt, gnt_nx;
  logic [1:0]       sel, sel_nx;
  logic [WIDTH-1:0] o, o_nx;
  logic             o_valid, o_valid_nx;

  logic [WIDTH-1:0] mux_word;
  logic             lock_on;
  logic             req_own;
  logic             can_move;
  logic             below_max;
  logic             release_g;
  logic             load_g;

  // First requesting index found when scanning base, base+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

  // HAL_MUX4 select code {S1,S2} for an owner: 0->11, 1->10, 2->01, 3->00.
  function automatic logic [1:0] enc(input logic [1:0] own);
    return ~own;
  endfunction

`ifdef HAL_ARB_LOCK_EN
  assign lock_on = bus.LOCK;
`else
  assign lock_on = 1'b0;
`endif

  // Shared datapath mux driven by the registered selects.
  always_comb begin
    case (sel)
      2'b11:   mux_word = bus.A;
      2'b10:   mux_word = bus.B;
      2'b01:   mux_word = bus.C;
      default: mux_word = bus.D;
    endcase
  end

  assign req_own   = bus.REQ[owner];
  assign can_move  = !o_valid || bus.READY;
  assign below_max = (cnt < HOLD);
  // Release beats load at the beat limit; an unaccepted beat blocks both.
  assign release_g = (!req_own || (!below_max && !lock_on)) && can_move;
  assign load_g    = req_own && (below_max || lock_on) && can_move && !release_g;

  // Next-state and next-register values; every target defaults to hold.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    gnt_nx     = gnt;
    sel_nx     = sel;
    o_nx       = o;
    o_valid_nx = o_valid;
    case (state)
      IDLE: begin
        if (bus.REQ != 4'b0000) begin
          owner_nx = pick(bus.REQ, ptr);
          gnt_nx   = 4'b0001 << owner_nx;
          sel_nx   = enc(owner_nx);
          cnt_nx   = 8'd0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (release_g) begin
          gnt_nx     = 4'b0000;
          o_valid_nx = 1'b0;
          ptr_nx     = owner + 2'd1;
          state_nx   = COOL;
        end else if (load_g) begin
          o_nx       = mux_word;
          o_valid_nx = 1'b1;
          if (below_max) cnt_nx = cnt + 8'd1;
        end else if (o_valid && bus.READY) begin
          o_valid_nx = 1'b0;
        end
      end
      COOL: begin
        // Selects hold for this cycle; arbitration resumes from IDLE.
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any grant and drops the beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      owner   <= 2'd0;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      gnt     <= 4'b0000;
      sel     <= 2'b00;
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      gnt     <= gnt_nx;
      sel     <= sel_nx;
      o       <= o_nx;
      o_valid <= o_valid_nx;
    end
  end

  assign bus.GNT     = gnt;
  assign bus.S1      = sel[1];
  assign bus.S2      = sel[0];
  assign bus.O       = o;
  assign bus.O_VALID = o_valid;
  assign bus.BUSY    = (state != IDLE);

endmodule
